ca_frame_gen: RTL
=================

CA_FRAME_GEN -- requirements
Module: ca_frame_gen

Interface
REQ-001 Parameter WIDTH, default 640, cells per generation / pixels per row.
REQ-002 Parameter HEIGHT, default 480, generations (rows) per frame.
REQ-003 Parameter X_W, default 10, x address width; Y_W, default 9, y address width.
REQ-004 iCLK  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle frame request; honoured in IDLE only.
REQ-007 run_cont  in  1  1 = restart a new frame automatically after DONE.
REQ-008 rule  in  8  Wolfram rule number.
REQ-009 wrap  in  1  1 = circular boundary, 0 = zero boundary.
REQ-010 seed_mode  in  1  0 = single centre cell, 1 = LFSR random row.
REQ-011 wr_ready  in  1  frame-buffer port accepts a write this cycle.
REQ-012 wr_en  out  1  write request; wr_addr  out  X_W+Y_W  {x,y}; wr_data  out  1  pixel.
REQ-013 busy  out  1; done  out  1  one-cycle frame-complete pulse; row  out  Y_W  current y.

Function
REQ-014 States SHALL be IDLE, SEED, WRITE, GEN, DONE.
REQ-015 IDLE: start=1 SHALL latch rule, wrap, seed_mode into frame registers and go to SEED; inputs changing mid-frame have no effect.
REQ-016 SEED, seed_mode=0: one cycle; cell[WIDTH/2]=1, all others 0; then WRITE.
REQ-017 SEED, seed_mode=1: WIDTH cycles; cycle k loads cell[k]=LFSR[0] and advances LFSR; then WRITE.
REQ-018 LFSR: 32 bits, shift right, new bit31 = bit0 XOR bit3, value 32'h55555555 after reset, not reloaded per frame.
REQ-019 WRITE: wr_en=1, wr_addr={x,row}, wr_data=cell[x]; x advances only on wr_en&&wr_ready; while wr_ready=0, addr and data held stable.
REQ-020 Accepted write at x=WIDTH-1: to GEN if row<HEIGHT-1, else to DONE.
REQ-021 GEN: one cycle; cell[i] <= rule[{L,C,R}], L=cell[i-1], C=cell[i], R=cell[i+1]; all WIDTH cells updated; row+1, x=0; then WRITE.
REQ-022 Boundary: wrap=1 -> cell[-1]=cell[WIDTH-1], cell[WIDTH]=cell[0]; wrap=0 -> both 0.
REQ-023 DONE: done=1 for exactly one cycle; next state SEED (with fresh latch of inputs) if run_cont=1, else IDLE.
REQ-024 Latency: start at edge N -> SEED in cycle N+1 -> first wr_en (x=0,y=0) in cycle N+2 for seed_mode=0.
REQ-025 Frame length without stalls, seed_mode=0: 1 + WIDTH*HEIGHT + (HEIGHT-1) + 1 cycles from SEED through DONE.
REQ-026 busy=1 in every state except IDLE; start while busy ignored.
REQ-027 wr_en SHALL be 0 outside WRITE.
REQ-028 x and row counters SHALL never exceed WIDTH-1 / HEIGHT-1; wr_addr upper bits zero-extended when WIDTH < 2^X_W.

Reset
REQ-029 reset=1 at any cycle, including mid-frame: state=IDLE, wr_en=0, done=0, busy=0, wr_addr=0, wr_data=0, row=0, all cells 0, LFSR=32'h55555555, next cycle.
REQ-030 reset has priority over start in the same cycle.

Configuration
REQ-031 Macro CA_RANDOM_SEED_EN defined: LFSR and seed_mode=1 behaviour present as above.
REQ-032 CA_RANDOM_SEED_EN undefined: no LFSR logic; seed_mode ignored; SEED always single centre cell.

Structure
REQ-033 Package ca_pkg SHALL hold the state enum, default WIDTH/HEIGHT, LFSR init value and tap positions.
REQ-034 Sub-module ca_next_row SHALL be the combinational WIDTH-cell rule evaluator (cells, rule, wrap in; next cells out).

Verification
REQ-035 WIDTH=16, HEIGHT=8, rule=90, wrap=0, seed_mode=0, wr_ready=1 -> row0 only x=8 set; row1 x=7,9; row2 x=6,10; done one cycle after last write; 1+128+7+1 cycles SEED..DONE.
REQ-036 WIDTH=8, HEIGHT=8, rule=8'hAA, seed_mode=0: wrap=1 -> row5 only x=7 set; wrap=0 -> row5 all zero.
REQ-037 wr_ready=0 for 3 cycles while x=5, row 0 -> wr_addr={5,0} and wr_data held; frame 3 cycles longer; no write skipped or duplicated.
REQ-038 reset pulsed at row 3 mid-WRITE -> next cycle wr_en=0, busy=0, state IDLE; subsequent start yields a frame identical to a clean one.
REQ-039 run_cont=1, two frames -> done pulses twice, single-cycle each, second frame first write {0,0} in cycle after DONE+SEED; start during frame ignored.
REQ-040 CA_RANDOM_SEED_EN defined, WIDTH=8, seed_mode=1 after reset -> row0 pixels x=0..7 = 1,0,1,0,1,0,1,0; SEED lasts 8 cycles.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton frame generator:
// FSM state encoding, default frame geometry and the seed LFSR constants.
package ca_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WRITE,
    S_GEN,
    S_DONE
  } state_t;

  localparam int CA_WIDTH_DEF  = 640;
  localparam int CA_HEIGHT_DEF = 480;

  localparam logic [31:0] LFSR_INIT  = 32'h5555_5555;
  localparam int          LFSR_TAP_A = 0;
  localparam int          LFSR_TAP_B = 3;

  // One right shift of the seed LFSR; the feedback enters at bit 31.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[LFSR_TAP_A] ^ s[LFSR_TAP_B], s[31:1]};
  endfunction

endpackage

// File: rtl/ca_next_row.sv
// Combinational elementary-CA evaluator: computes the next generation of a
// WIDTH-cell row from the Wolfram rule byte. With wrap set the row is a ring,
// otherwise the cells beyond both ends read as 0.
module ca_next_row
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cells,
  input  logic [7:0]       rule,
  input  logic             wrap,
  output logic [WIDTH-1:0] next_cells
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic l;
    logic r;
    if (i == 0) begin : g_l_edge
      assign l = wrap & cells[WIDTH-1];
    end else begin : g_l_in
      assign l = cells[i-1];
    end
    if (i == WIDTH - 1) begin : g_r_edge
      assign r = wrap & cells[0];
    end else begin : g_r_in
      assign r = cells[i+1];
    end
    assign next_cells[i] = rule[{l, cells[i], r}];
  end

endmodule

// File: rtl/ca_frame_gen.sv
// Elementary cellular-automaton frame generator. Seeds a row of WIDTH cells,
// streams every row into a frame buffer as {x,y} pixel writes with a
// wr_ready handshake, and evolves the row HEIGHT-1 times per frame.
// Optional build macro CA_RANDOM_SEED_EN adds the LFSR random-row seed
// (seed_mode=1); without it seed_mode is ignored and the seed is always a
// single centre cell.
module ca_frame_gen
  import ca_pkg::*;
#(
  parameter int WIDTH  = CA_WIDTH_DEF,
  parameter int HEIGHT = CA_HEIGHT_DEF,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic               iCLK,
  input  logic               reset,
  input  logic               start,
  input  logic               run_cont,
  input  logic [7:0]         rule,
  input  logic               wrap,
  input  logic               seed_mode,
  input  logic               wr_ready,
  output logic               wr_en,
  output logic [X_W+Y_W-1:0] wr_addr,
  output logic               wr_data,
  output logic               busy,
  output logic               done,
  output logic [Y_W-1:0]     row
);

  localparam logic [X_W-1:0]   X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(HEIGHT - 1);
  localparam logic [WIDTH-1:0] CENTRE = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH / 2);

  state_t           state;
  logic [X_W-1:0]   x;
  logic [WIDTH-1:0] cells;
  logic [WIDTH-1:0] cells_nxt;
  logic [7:0]       rule_f;
  logic             wrap_f;

`ifdef CA_RANDOM_SEED_EN
  logic             seed_f;
  logic [31:0]      lfsr;
`else
  logic             unused_seed_mode;
  assign unused_seed_mode = seed_mode;
`endif

  ca_next_row #(
    .WIDTH(WIDTH)
  ) u_next_row (
    .cells     (cells),
    .rule      (rule_f),
    .wrap      (wrap_f),
    .next_cells(cells_nxt)
  );

  // Frame sequencing: seed, write each row pixel by pixel, evolve, repeat.
  always_ff @(posedge iCLK) begin
    if (reset) begin
      state  <= S_IDLE;
      x      <= '0;
      row    <= '0;
      cells  <= '0;
      rule_f <= '0;
      wrap_f <= 1'b0;
`ifdef CA_RANDOM_SEED_EN
      seed_f <= 1'b0;
      lfsr   <= LFSR_INIT;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rule_f <= rule;
            wrap_f <= wrap;
`ifdef CA_RANDOM_SEED_EN
            seed_f <= seed_mode;
`endif
            state  <= S_SEED;
          end
        end
        S_SEED: begin
`ifdef CA_RANDOM_SEED_EN
          if (seed_f) begin
            // x doubles as the seed cell index; it is back at 0 for WRITE.
            cells[x] <= lfsr[0];
            lfsr     <= lfsr_step(lfsr);
            if (x == X_LAST) begin
              x     <= '0;
              state <= S_WRITE;
            end else begin
              x <= x + 1'b1;
            end
          end else begin
            cells <= CENTRE;
            state <= S_WRITE;
          end
`else
          cells <= CENTRE;
          state <= S_WRITE;
`endif
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (x == X_LAST) begin
              x     <= '0;
              state <= (row == Y_LAST) ? S_DONE : S_GEN;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        S_GEN: begin
          cells <= cells_nxt;
          row   <= row + 1'b1;
          state <= S_WRITE;
        end
        S_DONE: begin
          row <= '0;
          if (run_cont) begin
            rule_f <= rule;
            wrap_f <= wrap;
`ifdef CA_RANDOM_SEED_EN
            seed_f <= seed_mode;
`endif
            state  <= S_SEED;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state and counters only.
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign wr_en   = (state == S_WRITE);
  assign wr_addr = {x, row};
  assign wr_data = wr_en & cells[x];

endmodule
